vis_block_reader: RTL
=====================

# vis_block_reader

Wishbone-like bus master that drains visibility words from a correlator block's read-back port. Given a start pulse and a base address, it issues `COUNT` sequential single-word reads and delivers each returned word on a valid/ready output stream. It sits between the correlator blocks' bus interface and the SPI/readout path, on the bus clock.

## Interface

Parameters:
- `ACCUM`, default `ACCUM_BITS` (24): data word width.
- `ABITS`, default 10: bus address width, equal to 3 + TBITS + BBITS of the target block.
- `COUNT`, default 96: words per fetch, 12 time-slots × 8 words; legal range 1..2^ABITS.
- `CBITS`, default 7: word-counter width; must satisfy 2^CBITS ≥ COUNT.

Ports:
- `clk_i` in 1: bus clock; the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start_i` in 1: single-cycle pulse that begins a fetch; ignored while `busy_o`=1.
- `base_i` in ABITS: first word address, sampled when a start is accepted.
- `busy_o` out 1: fetch in progress.
- `done_o` out 1: one-cycle pulse after the last word is consumed, or after an abort.
- `err_o` out 1: sticky timeout flag, cleared by the next accepted start.
- `cyc_o` out 1: bus cycle, held for the entire fetch.
- `stb_o` out 1: one-cycle request strobe per word.
- `we_o` out 1: constant 0.
- `bst_o` out 1: bulk sequential transfer; 1 with every `stb_o` except the last word's.
- `adr_o` out ABITS: read address.
- `ack_i` in 1: bus acknowledge.
- `dat_i` in ACCUM: bus read data, valid while `ack_i`=1.
- `dat_o` out ACCUM: stream data.
- `valid_o` out 1: stream valid.
- `ready_i` in 1: stream ready.

## Operation

- States:
  - **IDLE**: on `start_i`, latch `adr`←`base_i`, `cnt`←0, clear `err_o`, then go to REQ.
  - **REQ**: `stb_o`=1 for exactly one cycle, then go to WAIT.
  - **WAIT**: `cyc_o`=1, `stb_o`=0. On `ack_i`, capture `dat_i` into `dat_o`, set `valid_o`, and go to HOLD.
  - **HOLD**: when `valid_o && ready_i`, clear `valid_o`. If `cnt`==COUNT-1, go to IDLE, drop `cyc_o`, and pulse `done_o`. Otherwise increment `cnt` and `adr`, then go to REQ.
- Only one request is outstanding at any time. A new request is never issued while `valid_o`=1, so no data is ever lost or overwritten.
- Addresses increment modulo 2^ABITS. A base near the top of the address space wraps to 0 with no error.
- `ack_i` is ignored outside WAIT, including spurious or late acknowledges.
- `start_i` coinciding with the final HOLD handshake is ignored; the block is still busy in that cycle.
- Outputs at reset: `busy_o`, `done_o`, `err_o`, `cyc_o`, `stb_o`, `we_o`, `bst_o`, and `valid_o` are 0; `adr_o` and `dat_o` are 0; state is IDLE.
- Reset asserted mid-fetch forces all of the above immediately. No `done_o` pulse is produced, and the partial fetch is discarded.

## Timing

- Against a slave with a two-register acknowledge:
  - `start_i` is accepted at cycle 0.
  - `stb_o` is high in cycle 1.
  - `ack_i` arrives in cycle 3.
  - `valid_o` is high in cycle 4.
- With `ready_i` held at 1, the next `stb_o` is in cycle 5, giving 4 cycles per word.
- `busy_o` rises in cycle 1 and falls in the same cycle as `done_o`.
- `cyc_o` is continuous from the first REQ to the final HOLD exit.
- `adr_o` is stable from REQ through the end of WAIT.

## Configuration

- `VIS_READER_TIMEOUT_EN` defined:
  - A 4-bit counter runs in WAIT.
  - If 16 cycles elapse without `ack_i`, the fetch aborts: `cyc_o` drops, `err_o` is set, `done_o` pulses, and state returns to IDLE.
  - `valid_o` is not asserted for the missing word.
- `VIS_READER_TIMEOUT_EN` undefined: WAIT waits indefinitely, and `err_o` is constant 0.

## Structure

- `ACCUM_BITS` and `BLOCK_BITS` come from `tartcfg.v`. The default TRATE and word-per-slot constants (12, 8) are defined there as well.
- The state encoding is local to the module.
- One sub-module: `bus_watchdog` (the timeout counter), instantiated only under `VIS_READER_TIMEOUT_EN`.

## Test plan

- **Single fetch:** COUNT=96, base 0x040, model slave with 2-cycle ack, `ready_i`=1 -> 96 words with `dat_o` == model[0x040+i] in order, `done_o` once, 384 cycles total.
- **Backpressure:** `ready_i` toggled pseudo-randomly -> no `stb_o` while `valid_o`=1, no word lost or duplicated, `dat_o` stable while stalled.
- **Wrap:** base 0x3F0, COUNT=32 -> `adr_o` sequence 0x3F0..0x3FF, 0x000..0x00F.
- **Reset mid-fetch:** `rst` asserted in the WAIT of word 10 -> all outputs 0 in the same cycle; a new start after reset refetches from the new base.
- **Ignored start:** start pulsed during a fetch -> no effect on address or count; `bst_o` low only on the word-95 strobe.
- **Timeout (`VIS_READER_TIMEOUT_EN`):** slave withholds ack on word 5 -> abort 16 cycles after the strobe, `err_o`=1, `done_o` pulse, exactly 5 words delivered; next start clears `err_o`.

Source files
------------

// File: rtl/vis_block_reader_pkg.sv
// Shared constants for the visibility block reader.
// Mirrors the correlator configuration: accumulator width, block address
// bits, and the default fetch length of 12 time-slots x 8 words.
package vis_block_reader_pkg;

  localparam int ACCUM_BITS      = 24;
  localparam int BLOCK_BITS      = 3;
  localparam int TRATE           = 12;
  localparam int WORDS_PER_SLOT  = 8;
  localparam int WORDS_PER_FETCH = TRATE * WORDS_PER_SLOT;
  localparam int WDOG_BITS       = 4;

endpackage

// File: rtl/vis_block_reader_bus_watchdog.sv
// Bus acknowledge watchdog for the visibility block reader.
// Counts consecutive cycles spent waiting for an acknowledge and flags
// expiry on the last allowed cycle (2^WDOG_BITS cycles) if no ack came.
// Only instantiated when VIS_READER_TIMEOUT_EN is defined.
module bus_watchdog
  import vis_block_reader_pkg::*;
(
  input  logic clk_i,
  input  logic rst,
  input  logic i_run,
  input  logic i_ack,
  output logic o_expire
);

  logic [WDOG_BITS-1:0] r_count;

  // Count waiting cycles; any ack or leaving the wait restarts from zero
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_run && !i_ack) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= '0;
    end
  end

  assign o_expire = i_run && !i_ack && (r_count == {WDOG_BITS{1'b1}});

endmodule

// File: rtl/vis_block_reader.sv
// Visibility block reader: Wishbone-like bus master that drains COUNT
// sequential words from a correlator block and hands each one out on a
// valid/ready stream. Exactly one bus request is outstanding at a time,
// and no new request is issued until the previous word is consumed.
// Optional feature: define VIS_READER_TIMEOUT_EN to abort a fetch when a
// slave fails to acknowledge within 16 cycles (sets sticky err_o).
module vis_block_reader
  import vis_block_reader_pkg::*;
#(
  parameter int ACCUM = ACCUM_BITS,
  parameter int ABITS = 10,
  parameter int COUNT = WORDS_PER_FETCH,
  parameter int CBITS = 7
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             start_i,
  input  logic [ABITS-1:0] base_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic             bst_o,
  output logic [ABITS-1:0] adr_o,
  input  logic             ack_i,
  input  logic [ACCUM-1:0] dat_i,
  output logic [ACCUM-1:0] dat_o,
  output logic             valid_o,
  input  logic             ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ABITS-1:0] r_adr;
  logic [CBITS-1:0] r_cnt;
  logic [ACCUM-1:0] r_dat;
  logic             r_done;
  logic             w_last;
  logic             w_accept;
  logic             w_capture;
  logic             w_consume;
  logic             w_timeout;

  assign w_last    = (r_cnt == CBITS'(COUNT - 1));
  assign w_accept  = (r_state == ST_IDLE) && start_i;
  assign w_capture = (r_state == ST_WAIT) && ack_i;
  assign w_consume = (r_state == ST_HOLD) && ready_i;

`ifdef VIS_READER_TIMEOUT_EN
  logic r_err;

  bus_watchdog u_watchdog (
    .clk_i    (clk_i),
    .rst      (rst),
    .i_run    (r_state == ST_WAIT),
    .i_ack    (ack_i),
    .o_expire (w_timeout)
  );

  // Sticky error: set by a watchdog abort, cleared when a new fetch starts
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and bus/stream outputs decoded from the current state
  always_comb begin
    w_next  = r_state;
    busy_o  = 1'b0;
    cyc_o   = 1'b0;
    stb_o   = 1'b0;
    bst_o   = 1'b0;
    valid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_next = ST_REQ;
        end
      end
      ST_REQ: begin
        busy_o = 1'b1;
        cyc_o  = 1'b1;
        stb_o  = 1'b1;
        bst_o  = !w_last;
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        busy_o = 1'b1;
        cyc_o  = 1'b1;
        if (ack_i) begin
          w_next = ST_HOLD;
        end else if (w_timeout) begin
          w_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        busy_o  = 1'b1;
        cyc_o   = 1'b1;
        valid_o = 1'b1;
        if (ready_i) begin
          w_next = w_last ? ST_IDLE : ST_REQ;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Address/count bookkeeping, read-data capture and the done pulse
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_adr  <= '0;
      r_cnt  <= '0;
      r_dat  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (w_consume && w_last) || w_timeout;
      if (w_accept) begin
        r_adr <= base_i;
        r_cnt <= '0;
      end else if (w_consume && !w_last) begin
        r_adr <= r_adr + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture) begin
        r_dat <= dat_i;
      end
    end
  end

  assign adr_o  = r_adr;
  assign dat_o  = r_dat;
  assign done_o = r_done;
  assign we_o   = 1'b0;

endmodule
